// File: rtl/scan_bcd_display_pkg.sv
// Shared types and constants for the scanned BCD counter display.
package scan_disp_pkg;

   typedef logic [3:0] digit_t;

   localparam digit_t BLANK_CODE = 4'hF;
   localparam digit_t BCD_MAX    = 4'd9;

endpackage

// File: rtl/scan_bcd_display_if.sv
// Counter controls into the display block and the multiplexed digit drive out of it.
interface scan_bcd_display_if #(
   parameter int NDIG = 4
) ();
   import scan_disp_pkg::*;

   logic            Cnt_en;
   logic            Clr;
   logic            Blank_lz;
   digit_t          Seg;
   logic [NDIG-1:0] Sl;
   logic            Ovf;

   modport master (
      output Cnt_en, Clr, Blank_lz,
      input  Seg, Sl, Ovf
   );

   modport slave (
      input  Cnt_en, Clr, Blank_lz,
      output Seg, Sl, Ovf
   );

endinterface

// File: rtl/scan_bcd_display_bcd_decade.sv
// One BCD decade of the counter: wraps 9->0 and reports a carry when it does.
module bcd_decade
   import scan_disp_pkg::*;
(
   input  logic   Clk,
   input  logic   Reset,
   input  logic   clr,
   input  logic   carry_in,
   output logic   carry_out,
   output digit_t digit
);

   // Carry-out is combinational so a carry ripples through every decade in one cycle.
   assign carry_out = carry_in && (digit >= BCD_MAX);

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         digit <= '0;
      end else if (clr) begin
         digit <= '0;
      end else if (carry_in) begin
         digit <= (digit >= BCD_MAX) ? '0 : digit + 4'd1;
      end
   end

endmodule

// File: rtl/scan_bcd_display.sv
// Prescaled NDIG-decade BCD counter with a multiplexed, optionally zero-blanked display scan.
module scan_bcd_display
   import scan_disp_pkg::*;
#(
   parameter int NDIG     = 4,
   parameter int PRESCALE = 5,
   parameter int SCAN_DIV = 1
) (
   input logic                Clk,
   input logic                Reset,
   scan_bcd_display_if.slave  bus
);

   localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SDIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = $clog2(NDIG);

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
   localparam logic [SDIV_W-1:0] SDIV_LAST = SDIV_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NDIG - 1);

   logic [PRE_W-1:0]  pre;
   logic [SDIV_W-1:0] sdiv;
   logic [IDX_W-1:0]  idx;
   logic [NDIG:0]     carry;
   digit_t            digits [NDIG];
   logic              zero_from_idx;
   logic [NDIG-1:0]   sl_n;
   logic              ovf_q;

   // Count path: prescaler feeds the decade chain.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pre <= '0;
      end else if (bus.Clr) begin
         pre <= '0;
      end else if (bus.Cnt_en) begin
         pre <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
      end
   end

   assign carry[0] = bus.Cnt_en && (pre == PRE_LAST);

   for (genvar k = 0; k < NDIG; k++) begin : g_decade
      bcd_decade u_decade (
         .Clk       (Clk),
         .Reset     (Reset),
         .clr       (bus.Clr),
         .carry_in  (carry[k]),
         .carry_out (carry[k+1]),
         .digit     (digits[k])
      );
   end

   // A carry out of the top decade means the count wrapped from all nines.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ovf_q <= 1'b0;
      end else if (bus.Clr) begin
         ovf_q <= 1'b0;
      end else if (carry[NDIG]) begin
         ovf_q <= 1'b1;
      end
   end

   // Display path runs free of the count controls so no scan position is ever skipped.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sdiv <= '0;
         idx  <= '0;
      end else if (sdiv == SDIV_LAST) begin
         sdiv <= '0;
         idx  <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
         sdiv <= sdiv + SDIV_W'(1);
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      sl_n      = '1;
      sl_n[idx] = 1'b0;
   end

   // Leading zero: the selected digit and every digit above it are zero.
   always_comb begin
      zero_from_idx = 1'b1;
      for (int k = 0; k < NDIG; k++) begin
         if ((k >= int'(idx)) && (digits[k] != '0)) zero_from_idx = 1'b0;
      end
   end

   assign bus.Seg = (bus.Blank_lz && (idx != '0) && zero_from_idx) ? BLANK_CODE : digits[idx];
   assign bus.Sl  = sl_n;
   assign bus.Ovf = ovf_q;

endmodule

// File: doc/scan_bcd_display.md
SCAN_BCD_DISPLAY -- requirements
Module: scan_bcd_display

Interface
REQ-001 Parameter NDIG, default 4: number of BCD digits and scan positions, legal range 2..8.
REQ-002 Parameter PRESCALE, default 5: qualified count-enable cycles per count increment, legal range 1..256.
REQ-003 Parameter SCAN_DIV, default 1: Clk cycles each digit stays selected, legal range 1..65536.
REQ-004 Clk  input  1  clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Cnt_en  input  1  count enable; each cycle high advances the prescaler.
REQ-007 Clr  input  1  synchronous clear of count, prescaler and Ovf.
REQ-008 Blank_lz  input  1  leading-zero blanking enable.
REQ-009 Seg  output  4  BCD code of the selected digit, or the blank code.
REQ-010 Sl  output  NDIG  digit select, active-low, one-hot.
REQ-011 Ovf  output  1  sticky overflow flag.

Function
REQ-012 Prescaler pre counts 0..PRESCALE-1; it increments on each cycle with Cnt_en=1 and holds otherwise.
REQ-013 Terminal event: Cnt_en=1 and pre=PRESCALE-1; pre returns to 0 and the count increments by exactly 1 in the same edge.
REQ-014 Count is NDIG BCD decades d[0] (LSD)..d[NDIG-1]; each decade stays in 0..9 at all times.
REQ-015 Increment uses a full ripple carry in one cycle: d[k] wraps 9->0 and carries into d[k+1] when d[0..k] are all 9.
REQ-016 Wrap-around: an increment from all 9s sets every digit to 0 and sets Ovf=1 in the same edge.
REQ-017 Ovf stays 1 until Clr or Reset; further wraps leave it at 1.
REQ-018 Clr=1 sets pre=0, all digits to 0 and Ovf=0 at the next edge; Clr wins over a simultaneous terminal event.
REQ-019 Scan divider sdiv counts 0..SCAN_DIV-1 every cycle regardless of Cnt_en and Clr.
REQ-020 When sdiv=SCAN_DIV-1, scan index idx advances by 1 and wraps from NDIG-1 to 0.
REQ-021 Sl = all ones except bit idx = 0; exactly one bit is low at all times outside reset.
REQ-022 Seg = d[idx], combinational from registered state, with zero-cycle latency relative to idx and digit registers.
REQ-023 Blanking: with Blank_lz=1, Seg = BLANK_CODE (4'hF) when d[idx]=0, idx>0, and all higher digits are 0.
REQ-024 Digit 0 is never blanked, so a zero count displays a single "0".
REQ-025 Blank_lz is sampled combinationally; a change takes effect on Seg in the same cycle.
REQ-026 Count and display paths are independent: counting never stalls or skips scan positions.

Reset
REQ-027 While Reset=1: pre=0, all digits 0, Ovf=0, sdiv=0, idx=0, giving Sl = all ones except bit 0 and Seg=4'h0.
REQ-028 Reset asserted mid-count or mid-scan aborts immediately, with no partial carry retained.
REQ-029 After deassertion, the first terminal event requires PRESCALE qualified Cnt_en cycles.

Structure
REQ-030 A shared package scan_disp_pkg holds BLANK_CODE=4'hF, the BCD_MAX=9 constant and the 4-bit digit typedef.
REQ-031 Sub-module bcd_decade (one digit register, with carry-in, clear and carry-out) is instantiated NDIG times via generate.
REQ-032 Prescaler, scan divider, select decode and blanking logic live in the top module.

Verification
REQ-033 NDIG=4, PRESCALE=5: hold Cnt_en=1 for 50 cycles -> count = 0010, Ovf=0.
REQ-034 Preload to 9999 by counting, then one further terminal event -> count 0000, Ovf=1; apply Clr -> Ovf=0.
REQ-035 Clr and terminal event in the same cycle -> count 0000, pre=0, no increment.
REQ-036 SCAN_DIV=3, count=0042, Blank_lz=1 -> over 12 cycles Sl sequence 1110,1101,1011,0111 with 3 cycles each, and Seg 2,4,F,F; with Blank_lz=0 -> Seg 2,4,0,0.
REQ-037 Cnt_en toggled 1/0 alternately, PRESCALE=5 -> one increment per 10 cycles while scan timing stays unchanged.
REQ-038 Reset pulsed while count=0137 and idx=2 -> outputs reach reset values immediately, and counting resumes from 0000.
